ps2_mouse_cmd_seq: RTL and testbench
====================================

# ps2_mouse_cmd_seq

Host-to-device command sequencer for the PS/2 mouse path. It drives the command side of `PS2_Controller` (`the_command`/`send_command`), which the canvas top level currently ties off. It also consumes the controller's received-byte stream to check ACK, self-test and ID responses. On success it reports a configured, streaming mouse (sample rate, resolution, reporting enabled) and hands the byte stream back to `PS2_Mouse_Parser`.

## Interface
- `SAMPLE_RATE`, default 8'd100: rate byte sent after F3. Legal values are 10/20/40/60/80/100/200.
- `RESOLUTION`, default 2'd2: byte sent after E8, giving 4 counts/mm.
- `RETRY_MAX`, default 3: resends allowed per byte before error.
- `ACK_TIMEOUT`, default 26'd5_000_000: cycles to wait for a response after `command_was_sent` (100 ms).
- `BAT_TIMEOUT`, default 26'd50_000_000: cycles to wait for AA after the FF ACK (1 s).
- `AUTO_START`, default 1: begin the sequence on the first cycle after reset release.
- `CLOCK_50` in 1: the single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request to run the sequence. Ignored while `busy`.
- `the_command` out 8: byte presented to the controller.
- `send_command` out 1: transmit request to the controller.
- `command_was_sent` in 1: pulse from the controller; the byte left the wire.
- `error_communication_timed_out` in 1: pulse from the controller; the transmit was not clocked out by the device.
- `received_data` in 8: byte from the device.
- `received_data_en` in 1: one-cycle strobe marking `received_data` valid.
- `busy` out 1: the sequence is in progress.
- `done` out 1: level; the sequence completed successfully.
- `error` out 1: level; the sequence aborted.
- `error_code` out 3: 0 none, 1 transmit timeout, 2 ACK timeout, 3 bad self-test (FC or non-AA), 4 unexpected byte.
- `stream_enable` out 1: high only while `done` is high; the parser gates packets with it.
- `has_wheel` out 1: the device answered ID 03. Only meaningful when the Configuration macro is defined.

## Operation
- Step list, in order:
  - FF, then wait for FA, then AA, then 00.
  - F3, FA, `SAMPLE_RATE`, FA.
  - E8, FA, `RESOLUTION`, FA.
  - F4, FA.
  - Enter DONE.
- FSM states: IDLE, SEND, WAIT_SENT, WAIT_RESP, WAIT_BAT, WAIT_ID, NEXT, DONE, ERROR.
- IDLE → SEND on `start`. Also on the first post-reset cycle if `AUTO_START` is set.
- Starting clears `done`, `error`, `error_code`, `has_wheel` and the step and retry counters. Sets `busy`.
- SEND:
  - Load `the_command` from the step list.
  - Raise `send_command`.
  - Go to WAIT_SENT.
- WAIT_SENT:
  - Hold `send_command` high and `the_command` stable.
  - On `command_was_sent`: drop `send_command` and go to WAIT_RESP.
  - On `error_communication_timed_out`: drop `send_command` and count a retry.
- WAIT_RESP, on each byte:
  - FA: zero the retry counter and go to NEXT. After FF, go to WAIT_BAT instead.
  - FE: count a retry, then resend the same byte.
  - FC: enter ERROR with code 3.
  - Any other byte: count a retry.
- WAIT_BAT:
  - AA → WAIT_ID.
  - Any other byte, or `BAT_TIMEOUT` expiry → ERROR with code 3.
- WAIT_ID:
  - 00 → NEXT. Any other byte → ERROR with code 4.
  - Timeout uses `ACK_TIMEOUT` → ERROR with code 2.
- A retry increments the per-byte counter and returns to SEND. Once the counter reaches `RETRY_MAX`, enter ERROR instead, with the code of the triggering cause.
- NEXT: advance the step index. Go to DONE after the last step, otherwise to SEND.
- DONE: `done`=1, `busy`=0, `stream_enable`=1. Received bytes are ignored by this block.
- ERROR: `error`=1, `busy`=0, `stream_enable`=0. Returns to SEND only through `start`.

## Timing
- Reset values:
  - All outputs 0 and `the_command`=8'h00.
  - State IDLE, counters 0.
  - A reset mid-transfer drops `send_command` immediately.
- `send_command` rises the cycle after entering SEND. It falls on the cycle after `command_was_sent` or `error_communication_timed_out`.
- `send_command` stays low for at least 1 cycle between bytes.
- The response timer starts at 0 on the cycle `command_was_sent` is seen. It expires when it equals the active timeout.
- If `received_data_en` and timer expiry land on the same cycle, the byte wins.
- Bytes arriving in IDLE, SEND or WAIT_SENT are discarded.
- `start` asserted in the same cycle as entering DONE or ERROR is ignored; only the next cycle's `start` restarts.
- Timer is 26 bits, saturating; it never wraps.

## Configuration
- `PS2_INTELLIMOUSE_EN` defined:
  - After the F4 step is withheld, insert F3 C8, F3 64, F3 50, then F2. Each byte requires FA.
  - F2 is followed by an ID byte in WAIT_ID: 03 sets `has_wheel`; 00 leaves it 0.
  - Then send F3 `SAMPLE_RATE` and F4.
- Not defined: these steps are absent and `has_wheel` is tied to 0.

## Structure
- Package `ps2_mouse_pkg` holds:
  - Command constants: FF, F4, F3, E8, F2.
  - Response constants: FA, FE, FC, AA.
  - Error-code constants.
  - The state enum.
- Sub-module `ps2_cmd_xfer` is natural. It performs one byte transaction (SEND/WAIT_SENT/WAIT_RESP plus timer) and returns the result: ack, resend, fc, timeout or unexpected.
- The top-level FSM then only walks the step list and counts retries.

## Test plan
- Clean run, `AUTO_START`=1, device model ACKs everything:
  - Bytes sent are FF, F3, 64, E8, 02, F4.
  - The device replies AA 00 after the FF ACK.
  - `done`=1 and `stream_enable`=1; `error_code`=0.
- Device answers FE twice to F3, then FA: F3 is transmitted 3 times and the sequence still completes.
- Device never answers E8: after 4 transmissions and `ACK_TIMEOUT` cycles each, `error`=1 and `error_code`=2.
- Device replies FC after the FF ACK: `error_code`=3 and no further bytes are sent.
- `error_communication_timed_out` pulsed on every F4 attempt: `error_code`=1, and `send_command` is low in ERROR.
- `reset_n` low during WAIT_SENT of the rate byte:
  - All outputs return to 0 asynchronously.
  - Reset release reruns the sequence from FF.
  - With `PS2_INTELLIMOUSE_EN` and ID 03 returned, `has_wheel`=1.

Source files
------------

// File: rtl/ps2_mouse_pkg.sv
`default_nettype none
// ============================================================================
// ps2_mouse_pkg
// PS/2 mouse command/response bytes, error codes, FSM states, response kinds.
// Rev 1.0
// ============================================================================
package ps2_mouse_pkg;

    localparam logic [7:0] c_cmd_reset    = 8'hFF;
    localparam logic [7:0] c_cmd_enable   = 8'hF4;
    localparam logic [7:0] c_cmd_set_rate = 8'hF3;
    localparam logic [7:0] c_cmd_set_res  = 8'hE8;
    localparam logic [7:0] c_cmd_get_id   = 8'hF2;

    localparam logic [7:0] c_rsp_ack      = 8'hFA;
    localparam logic [7:0] c_rsp_resend   = 8'hFE;
    localparam logic [7:0] c_rsp_error    = 8'hFC;
    localparam logic [7:0] c_rsp_bat_ok   = 8'hAA;
    localparam logic [7:0] c_rsp_id_std   = 8'h00;
    localparam logic [7:0] c_rsp_id_wheel = 8'h03;

    localparam logic [2:0] c_err_none        = 3'd0;
    localparam logic [2:0] c_err_tx_timeout  = 3'd1;
    localparam logic [2:0] c_err_ack_timeout = 3'd2;
    localparam logic [2:0] c_err_self_test   = 3'd3;
    localparam logic [2:0] c_err_unexpected  = 3'd4;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_SEND      = 4'd1,
        ST_WAIT_SENT = 4'd2,
        ST_WAIT_RESP = 4'd3,
        ST_WAIT_BAT  = 4'd4,
        ST_WAIT_ID   = 4'd5,
        ST_NEXT      = 4'd6,
        ST_DONE      = 4'd7,
        ST_ERROR     = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        RES_NONE     = 3'd0,
        RES_ACK      = 3'd1,
        RES_RESEND   = 3'd2,
        RES_FC       = 3'd3,
        RES_AA       = 3'd4,
        RES_ID_STD   = 3'd5,
        RES_ID_WHEEL = 3'd6,
        RES_OTHER    = 3'd7
    } resp_t;

    function automatic resp_t classify(input logic [7:0] b);
        case (b)
            c_rsp_ack:      return RES_ACK;
            c_rsp_resend:   return RES_RESEND;
            c_rsp_error:    return RES_FC;
            c_rsp_bat_ok:   return RES_AA;
            c_rsp_id_std:   return RES_ID_STD;
            c_rsp_id_wheel: return RES_ID_WHEEL;
            default:        return RES_OTHER;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_mouse_cmd_seq_if.sv
`default_nettype none
// ============================================================================
// ps2_mouse_cmd_seq_if
// Command/response link between the sequencer and PS2_Controller.
// Rev 1.0
// ============================================================================
interface ps2_mouse_cmd_seq_if;
    logic [7:0] the_command;
    logic       send_command;
    logic       command_was_sent;
    logic       error_communication_timed_out;
    logic [7:0] received_data;
    logic       received_data_en;

    modport master (
        output the_command,
        output send_command,
        input  command_was_sent,
        input  error_communication_timed_out,
        input  received_data,
        input  received_data_en
    );

    modport slave (
        input  the_command,
        input  send_command,
        output command_was_sent,
        output error_communication_timed_out,
        output received_data,
        output received_data_en
    );
endinterface
`default_nettype wire

// File: rtl/ps2_cmd_xfer.sv
`default_nettype none
// ============================================================================
// ps2_cmd_xfer
// Response watcher for one command transaction: saturating wait timer plus
// classification of each received byte.
// Rev 1.0
// ============================================================================
module ps2_cmd_xfer
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned TIMER_W = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               restart,
    input  logic [TIMER_W-1:0] timeout,
    input  logic [7:0]         rx_data,
    input  logic               rx_en,
    output resp_t              result,
    output logic               expired
);

    logic [TIMER_W-1:0] r_timer;

    // Restarted on every state change so it measures time spent in the current wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (restart) begin
            r_timer <= '0;
        end else if (r_timer != {TIMER_W{1'b1}}) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign expired = (r_timer == timeout);
    assign result  = rx_en ? classify(rx_data) : RES_NONE;

endmodule
`default_nettype wire

// File: rtl/ps2_mouse_cmd_seq.sv
`default_nettype none
// ============================================================================
// ps2_mouse_cmd_seq
// Host-to-device PS/2 mouse init sequencer (reset, rate, resolution, enable).
// Optional IntelliMouse wheel detection: define PS2_INTELLIMOUSE_EN.
// Rev 1.0
// ============================================================================
module ps2_mouse_cmd_seq
    import ps2_mouse_pkg::*;
#(
    parameter logic [7:0]  SAMPLE_RATE = 8'd100,
    parameter logic [1:0]  RESOLUTION  = 2'd2,
    parameter int unsigned RETRY_MAX   = 3,
    parameter logic [25:0] ACK_TIMEOUT = 26'd5_000_000,
    parameter logic [25:0] BAT_TIMEOUT = 26'd50_000_000,
    parameter bit          AUTO_START  = 1'b1
) (
    input  logic                     CLOCK_50,
    input  logic                     reset_n,
    input  logic                     start,
    ps2_mouse_cmd_seq_if.master      ps2,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [2:0]               error_code,
    output logic                     stream_enable,
    output logic                     has_wheel
);

`ifdef PS2_INTELLIMOUSE_EN
    localparam logic [3:0] c_last_step = 4'd14;
`else
    localparam logic [3:0] c_last_step = 4'd5;
`endif

    state_t      r_state;
    state_t      w_state_next;
    logic        r_auto;
    logic [3:0]  r_step;
    logic [3:0]  r_retry;
    logic [7:0]  r_cmd;
    logic [2:0]  r_err;
    logic [7:0]  w_step_byte;
    logic        w_go;
    logic        w_launch;
    logic        w_retry;
    logic        w_fail;
    logic        w_exhausted;
    logic        w_abort;
    logic [2:0]  w_code;
    logic        w_send;
    logic        w_id_wheel_ok;
    logic        w_restart;
    logic [25:0] w_timeout;
    resp_t       w_result;
    logic        w_expired;

    assign w_go        = start | r_auto;
    assign w_launch    = (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERROR) && w_go;
    assign w_exhausted = (r_retry == RETRY_MAX[3:0]);
    assign w_abort     = w_fail | (w_retry & w_exhausted);
    assign w_restart   = (r_state != w_state_next);
    assign w_timeout   = (r_state == ST_WAIT_BAT) ? BAT_TIMEOUT : ACK_TIMEOUT;

    ps2_cmd_xfer #(
        .TIMER_W (26)
    ) u_xfer (
        .clk     (CLOCK_50),
        .rst_n   (reset_n),
        .restart (w_restart),
        .timeout (w_timeout),
        .rx_data (ps2.received_data),
        .rx_en   (ps2.received_data_en),
        .result  (w_result),
        .expired (w_expired)
    );

    always_comb begin
        w_step_byte = c_cmd_enable;
        case (r_step)
            4'd0:    w_step_byte = c_cmd_reset;
            4'd1:    w_step_byte = c_cmd_set_rate;
            4'd2:    w_step_byte = SAMPLE_RATE;
            4'd3:    w_step_byte = c_cmd_set_res;
            4'd4:    w_step_byte = {6'b0, RESOLUTION};
`ifdef PS2_INTELLIMOUSE_EN
            // Rate knock 200/100/80 unlocks the wheel ID on IntelliMouse devices
            4'd5:    w_step_byte = c_cmd_set_rate;
            4'd6:    w_step_byte = 8'hC8;
            4'd7:    w_step_byte = c_cmd_set_rate;
            4'd8:    w_step_byte = 8'h64;
            4'd9:    w_step_byte = c_cmd_set_rate;
            4'd10:   w_step_byte = 8'h50;
            4'd11:   w_step_byte = c_cmd_get_id;
            4'd12:   w_step_byte = c_cmd_set_rate;
            4'd13:   w_step_byte = SAMPLE_RATE;
`endif
            default: w_step_byte = c_cmd_enable;
        endcase
    end

`ifdef PS2_INTELLIMOUSE_EN
    assign w_id_wheel_ok = (w_result == RES_ID_WHEEL) && (r_cmd == c_cmd_get_id);
`else
    assign w_id_wheel_ok = 1'b0;
`endif

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_retry      = 1'b0;
        w_fail       = 1'b0;
        w_code       = c_err_none;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (w_go) w_state_next = ST_SEND;
            end
            ST_SEND: w_state_next = ST_WAIT_SENT;
            ST_WAIT_SENT: begin
                if (ps2.command_was_sent) begin
                    w_state_next = ST_WAIT_RESP;
                end else if (ps2.error_communication_timed_out) begin
                    w_retry = 1'b1;
                    w_code  = c_err_tx_timeout;
                end
            end
            ST_WAIT_RESP: begin
                case (w_result)
                    RES_NONE: begin
                        if (w_expired) begin
                            w_retry = 1'b1;
                            w_code  = c_err_ack_timeout;
                        end
                    end
                    RES_ACK: begin
                        if (r_cmd == c_cmd_reset)       w_state_next = ST_WAIT_BAT;
                        else if (r_cmd == c_cmd_get_id) w_state_next = ST_WAIT_ID;
                        else                            w_state_next = ST_NEXT;
                    end
                    RES_FC: begin
                        w_fail = 1'b1;
                        w_code = c_err_self_test;
                    end
                    default: begin
                        w_retry = 1'b1;
                        w_code  = c_err_unexpected;
                    end
                endcase
            end
            ST_WAIT_BAT: begin
                if (w_result == RES_AA) begin
                    w_state_next = ST_WAIT_ID;
                end else if (w_result != RES_NONE || w_expired) begin
                    w_fail = 1'b1;
                    w_code = c_err_self_test;
                end
            end
            ST_WAIT_ID: begin
                if (w_result == RES_ID_STD || w_id_wheel_ok) begin
                    w_state_next = ST_NEXT;
                end else if (w_result != RES_NONE) begin
                    w_fail = 1'b1;
                    w_code = c_err_unexpected;
                end else if (w_expired) begin
                    w_fail = 1'b1;
                    w_code = c_err_ack_timeout;
                end
            end
            ST_NEXT: w_state_next = (r_step == c_last_step) ? ST_DONE : ST_SEND;
            default: w_state_next = ST_IDLE;
        endcase
        if (w_abort)      w_state_next = ST_ERROR;
        else if (w_retry) w_state_next = ST_SEND;
    end

    always_comb begin
        w_send        = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        error         = 1'b0;
        stream_enable = 1'b0;
        case (r_state)
            ST_IDLE: ;
            ST_WAIT_SENT: begin
                w_send = 1'b1;
                busy   = 1'b1;
            end
            ST_DONE: begin
                done          = 1'b1;
                stream_enable = 1'b1;
            end
            ST_ERROR: error = 1'b1;
            default:  busy  = 1'b1;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_auto  <= AUTO_START;
            r_cmd   <= 8'h00;
            r_step  <= 4'd0;
            r_retry <= 4'd0;
            r_err   <= c_err_none;
        end else begin
            r_auto <= 1'b0;
            if (w_launch) begin
                r_step  <= 4'd0;
                r_retry <= 4'd0;
                r_err   <= c_err_none;
            end else begin
                if (r_state == ST_SEND) r_cmd <= w_step_byte;
                if (r_state == ST_NEXT && r_step != c_last_step) r_step <= r_step + 1'b1;
                if (r_state == ST_WAIT_RESP && w_result == RES_ACK) begin
                    r_retry <= 4'd0;
                end else if (w_retry && !w_exhausted) begin
                    r_retry <= r_retry + 1'b1;
                end
                if (w_abort) r_err <= w_code;
            end
        end
    end

`ifdef PS2_INTELLIMOUSE_EN
    logic r_has_wheel;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_has_wheel <= 1'b0;
        end else if (w_launch) begin
            r_has_wheel <= 1'b0;
        end else if (r_state == ST_WAIT_ID && w_id_wheel_ok) begin
            r_has_wheel <= 1'b1;
        end
    end

    assign has_wheel = r_has_wheel;
`else
    assign has_wheel = 1'b0;
`endif

    assign error_code      = r_err;
    assign ps2.the_command  = r_cmd;
    assign ps2.send_command = w_send;

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_cmd_seq.sv
`default_nettype none
// ============================================================================
// tb_ps2_mouse_cmd_seq
// Directed bench acting as PS2_Controller plus device for the sequencer.
// Rev 1.0
// ============================================================================
module tb_ps2_mouse_cmd_seq;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, error, stream_enable, has_wheel;
    logic [2:0] error_code;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         highs;
    bit         seen;

    ps2_mouse_cmd_seq_if ps2 ();

    ps2_mouse_cmd_seq #(
        .SAMPLE_RATE (8'd100),
        .RESOLUTION  (2'd2),
        .RETRY_MAX   (3),
        .ACK_TIMEOUT (26'd40),
        .BAT_TIMEOUT (26'd60),
        .AUTO_START  (1'b1)
    ) dut (
        .CLOCK_50      (clk),
        .reset_n       (rst_n),
        .start         (start),
        .ps2           (ps2.master),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .error_code    (error_code),
        .stream_enable (stream_enable),
        .has_wheel     (has_wheel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_send(input string tag, output bit found);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ps2.send_command === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, 32'(found), 32'd1);
    endtask

    task automatic cmd(input string tag, input logic [7:0] exp);
        bit f;
        wait_send(tag, f);
        check(tag, 32'(ps2.the_command), 32'(exp));
        ps2.command_was_sent = 1'b1;
        @(negedge clk);
        ps2.command_was_sent = 1'b0;
        check({tag, "_drop"}, 32'(ps2.send_command), 32'd0);
    endtask

    task automatic tx_fail(input string tag, input logic [7:0] exp);
        bit f;
        wait_send(tag, f);
        check(tag, 32'(ps2.the_command), 32'(exp));
        ps2.error_communication_timed_out = 1'b1;
        @(negedge clk);
        ps2.error_communication_timed_out = 1'b0;
    endtask

    task automatic rx(input logic [7:0] b);
        ps2.received_data    = b;
        ps2.received_data_en = 1'b1;
        @(negedge clk);
        ps2.received_data_en = 1'b0;
        ps2.received_data    = 8'h00;
    endtask

    task automatic cmd_ack(input string tag, input logic [7:0] exp);
        cmd(tag, exp);
        rx(8'hFA);
    endtask

    task automatic prefix();
        cmd("ff", 8'hFF);
        rx(8'hFA);
        rx(8'hAA);
        rx(8'h00);
    endtask

    task automatic body();
        cmd_ack("f3", 8'hF3);
        cmd_ack("rate", 8'h64);
        cmd_ack("e8", 8'hE8);
        cmd_ack("res", 8'h02);
    endtask

    task automatic mid(input logic [7:0] id);
`ifdef PS2_INTELLIMOUSE_EN
        cmd_ack("k1", 8'hF3); cmd_ack("k1v", 8'hC8);
        cmd_ack("k2", 8'hF3); cmd_ack("k2v", 8'h64);
        cmd_ack("k3", 8'hF3); cmd_ack("k3v", 8'h50);
        cmd("f2", 8'hF2);
        rx(8'hFA);
        rx(id);
        cmd_ack("f3b", 8'hF3); cmd_ack("rateb", 8'h64);
`else
        check("id_unused", 32'(id === 8'hxx), 32'd0);
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        ps2.command_was_sent              = 1'b0;
        ps2.error_communication_timed_out = 1'b0;
        ps2.received_data                 = 8'h00;
        ps2.received_data_en              = 1'b0;

        // Reset state
        idle(3);
        check("rst_ctl", 32'({ps2.send_command, busy, done, error, stream_enable, has_wheel}), 32'd0);
        check("rst_code", 32'(error_code), 32'd0);
        check("rst_cmd", 32'(ps2.the_command), 32'd0);
        rst_n = 1'b1;

        // Clean auto-started run
        prefix();
        check("busy_run", 32'(busy), 32'd1);
        body();
        mid(8'h00);
        cmd_ack("f4", 8'hF4);
        idle(3);
        check("clean_done", 32'({done, stream_enable, busy, error}), 32'b1100);
        check("clean_code", 32'(error_code), 32'd0);
        rx(8'hFC);
        idle(2);
        check("done_ignores_rx", 32'({done, error}), 32'b10);

        // Two resends of F3, third attempt acknowledged
        pulse_start();
        prefix();
        cmd("f3_try1", 8'hF3); rx(8'hFE);
        cmd("f3_try2", 8'hF3); rx(8'hFE);
        cmd("f3_try3", 8'hF3); rx(8'hFA);
        cmd_ack("rate", 8'h64);
        cmd_ack("e8", 8'hE8);
        cmd_ack("res", 8'h02);
        mid(8'h00);
        cmd_ack("f4", 8'hF4);
        idle(3);
        check("fe_done", 32'({done, error}), 32'b10);

        // E8 never answered: four transmissions then ACK timeout
        pulse_start();
        prefix();
        cmd_ack("f3", 8'hF3);
        cmd_ack("rate", 8'h64);
        cmd("e8_try1", 8'hE8);
        cmd("e8_try2", 8'hE8);
        cmd("e8_try3", 8'hE8);
        cmd("e8_try4", 8'hE8);
        idle(60);
        check("ackto_flags", 32'({error, done, busy, stream_enable, ps2.send_command}), 32'b10000);
        check("ackto_code", 32'(error_code), 32'd2);

        // FC after the FF ACK
        pulse_start();
        check("start_clears", 32'({error, error_code}), 32'd0);
        cmd("ff", 8'hFF);
        rx(8'hFA);
        rx(8'hFC);
        idle(2);
        check("fc_error", 32'(error), 32'd1);
        check("fc_code", 32'(error_code), 32'd3);
        highs = 0;
        repeat (50) begin
            @(negedge clk);
            if (ps2.send_command === 1'b1) highs++;
        end
        check("fc_quiet", 32'(highs), 32'd0);

        // Transmit timeout on every F4 attempt
        pulse_start();
        prefix();
        body();
        mid(8'h00);
        tx_fail("f4_tx1", 8'hF4);
        tx_fail("f4_tx2", 8'hF4);
        tx_fail("f4_tx3", 8'hF4);
        tx_fail("f4_tx4", 8'hF4);
        idle(3);
        check("txto_code", 32'(error_code), 32'd1);
        check("txto_flags", 32'({error, ps2.send_command, busy}), 32'b100);

        // Reset while the rate byte is on the wire
        pulse_start();
        prefix();
        cmd_ack("f3", 8'hF3);
        wait_send("rate_hold", seen);
        check("rate_hold_cmd", 32'(ps2.the_command), 32'h64);
        rst_n = 1'b0;
        #1;
        check("arst_ctl", 32'({ps2.send_command, busy, done, error, stream_enable, has_wheel}), 32'd0);
        check("arst_data", 32'({ps2.the_command, 5'd0, error_code}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prefix();
        body();
        mid(8'h03);
        cmd_ack("f4", 8'hF4);
        idle(3);
        check("rerun_done", 32'({done, stream_enable, error}), 32'b110);
`ifdef PS2_INTELLIMOUSE_EN
        check("wheel", 32'(has_wheel), 32'd1);
`else
        check("wheel", 32'(has_wheel), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
